// File: rtl/norm_param_ctrl_pkg.sv
// Shared definitions for the normalisation parameter buffer controller.
package norm_param_ctrl_pkg;

  localparam int DEF_WIDTH     = 64;
  localparam int DEF_ADDR_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SERVE = 2'd2
  } norm_state_e;

endpackage

// File: rtl/Configurable_RAM_Norm.sv
// Distributed parameter RAM: synchronous write, asynchronous read.
module Configurable_RAM_Norm #(
  parameter int WIDTH     = 64,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 write_enable,
  input  logic [ADDR_BITS-1:0] write_address,
  input  logic [WIDTH-1:0]     write_data,
  input  logic [ADDR_BITS-1:0] read_address,
  output logic [WIDTH-1:0]     read_data
);

  logic [WIDTH-1:0] mem [2**ADDR_BITS];

  // Write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (write_enable) mem[write_address] <= write_data;
  end

  assign read_data = mem[read_address];

endmodule

// File: rtl/norm_param_ctrl.sv
// Normalisation parameter buffer controller: loads a layer's parameter
// words from the stream into the RAM, then serves registered reads.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | after reset, nothing loaded; stream and reads ignored
//   ST_LOAD  | accepting stream beats, writing RAM at wr_ptr
//   ST_SERVE | load complete; reads served, start triggers a reload
module norm_param_ctrl
  import norm_param_ctrl_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_BITS:0]   param_count,
  input  logic [WIDTH-1:0]     s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 load_done,
  output logic                 busy,
  input  logic                 rd_req,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic                 rd_valid,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_oob
);

  localparam logic [ADDR_BITS:0] CAPACITY = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0] ONE      = {{ADDR_BITS{1'b0}}, 1'b1};

  norm_state_e state_q, state_d;

  logic [ADDR_BITS-1:0] wr_ptr_q;
  logic [ADDR_BITS:0]   count_q;
  logic [ADDR_BITS:0]   beats_left_q;
  logic [ADDR_BITS:0]   loaded_q;
  logic [ADDR_BITS:0]   count_clamped;
  logic                 start_ok;
  logic                 beat;
  logic                 last_beat;
  logic                 rd_accept;
  logic                 rd_in_range;
  logic [WIDTH-1:0]     ram_rd_data;

  assign count_clamped = (param_count > CAPACITY) ? CAPACITY : param_count;
  assign start_ok      = start && (state_q != ST_LOAD);
  assign beat          = s_valid && (state_q == ST_LOAD);
  // Completion comes from the remaining-beat down-counter, so a full-depth
  // load ends cleanly even though wr_ptr wraps back to zero.
  assign last_beat     = beat && (beats_left_q == ONE);
  assign rd_accept     = rd_req && (state_q == ST_SERVE);
  assign rd_in_range   = {1'b0, rd_addr} < loaded_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and stream handshake outputs.
  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    busy    = 1'b0;
    case (state_q)
      ST_IDLE, ST_SERVE: begin
        if (start) state_d = (count_clamped == '0) ? ST_SERVE : ST_LOAD;
      end
      ST_LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (last_beat) state_d = ST_SERVE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Load bookkeeping: write pointer, beat down-counter, loaded count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      count_q      <= '0;
      beats_left_q <= '0;
      loaded_q     <= '0;
      load_done    <= 1'b0;
    end else begin
      load_done <= last_beat || (start_ok && (count_clamped == '0));
      if (start_ok) begin
        wr_ptr_q     <= '0;
        count_q      <= count_clamped;
        beats_left_q <= count_clamped;
        if (count_clamped == '0) loaded_q <= '0;
      end else if (beat) begin
        wr_ptr_q     <= wr_ptr_q + 1'b1;
        beats_left_q <= beats_left_q - ONE;
        if (last_beat) loaded_q <= count_q;
      end
    end
  end

  // Registered read response; rd_data holds between accepted requests.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_oob   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_accept;
      rd_oob   <= rd_accept && !rd_in_range;
      if (rd_accept) rd_data <= rd_in_range ? ram_rd_data : '0;
    end
  end

  Configurable_RAM_Norm #(
    .WIDTH     (WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk           (clk),
    .write_enable  (beat),
    .write_address (wr_ptr_q),
    .write_data    (s_data),
    .read_address  (rd_addr),
    .read_data     (ram_rd_data)
  );

endmodule

// File: tb/tb_norm_param_ctrl.sv
// Scoreboard bench for norm_param_ctrl: stimulus pushes expected read
// responses, a negedge monitor pops and compares them.
module tb_norm_param_ctrl;

  localparam int W     = 64;
  localparam int AB    = 10;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AB:0]   param_count = '0;
  logic [W-1:0]  s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          load_done;
  logic          busy;
  logic          rd_req = 1'b0;
  logic [AB-1:0] rd_addr = '0;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic          rd_oob;

  always #5 clk = ~clk;

  norm_param_ctrl #(.WIDTH(W), .ADDR_BITS(AB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .param_count (param_count),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .load_done   (load_done),
    .busy        (busy),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_oob      (rd_oob)
  );

  logic [W-1:0] model [DEPTH];
  int           m_loaded = 0;
  bit           m_serve  = 1'b0;
  logic [W:0]   exp_q [$];
  int           n_pass  = 0;
  int           n_total = 0;

  task automatic chk64(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] beat_val(input int mode, input int i);
    case (mode)
      0:       return 64'(i + 1) * 64'h11;
      1:       return 64'(i);
      2:       return 64'hA5A5_0000_0000_0000 | 64'(i);
      default: return 64'hDEAD_0000 + 64'(i);
    endcase
  endfunction

  function automatic void push_exp(input int a);
    if (!m_serve) return;
    if (a < m_loaded) exp_q.push_back({1'b0, model[a]});
    else              exp_q.push_back({1'b1, 64'd0});
  endfunction

  task automatic rd_seq(input int first, input int n);
    for (int a = first; a < first + n; a++) begin
      rd_req  = 1'b1;
      rd_addr = AB'(a);
      push_exp(a);
      tick();
    end
    rd_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk1({tag, "_s_ready"},   s_ready,   1'b0);
    chk1({tag, "_load_done"}, load_done, 1'b0);
    chk1({tag, "_busy"},      busy,      1'b0);
    chk1({tag, "_rd_valid"},  rd_valid,  1'b0);
    chk64({tag, "_rd_data"},  rd_data,   64'd0);
    chk1({tag, "_rd_oob"},    rd_oob,    1'b0);
  endtask

  task automatic do_load(input int n, input int mode, input bit toggle,
                         input bit rd_with_start, input int rd_a);
    int eff;
    eff = (n > DEPTH) ? DEPTH : n;
    param_count = (AB+1)'(n);
    start = 1'b1;
    if (rd_with_start) begin
      rd_req  = 1'b1;
      rd_addr = AB'(rd_a);
      push_exp(rd_a);
    end
    tick();
    start  = 1'b0;
    rd_req = 1'b0;
    if (eff == 0) begin
      chk1("zero_load_done", load_done, 1'b1);
      chk1("zero_s_ready",   s_ready,   1'b0);
      chk1("zero_busy",      busy,      1'b0);
      m_serve  = 1'b1;
      m_loaded = 0;
      return;
    end
    m_serve = 1'b0;
    chk1("start_s_ready", s_ready, 1'b1);
    chk1("start_busy",    busy,    1'b1);
    for (int i = 0; i < eff; i++) begin
      s_valid  = 1'b1;
      s_data   = beat_val(mode, i);
      model[i] = s_data;
      tick();
      if (toggle && i < eff - 1) begin
        s_valid = 1'b0;
        s_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        chk1("gap_load_done", load_done, 1'b0);
        tick();
      end
    end
    s_valid = 1'b0;
    chk1("done_load_done", load_done, 1'b1);
    chk1("done_s_ready",   s_ready,   1'b0);
    chk1("done_busy",      busy,      1'b0);
    m_serve  = 1'b1;
    m_loaded = eff;
  endtask

  // Monitor: every rd_valid must match the oldest expected response.
  always @(negedge clk) begin : monitor
    logic [W:0] e;
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_rd_valid: got rd_valid=1 expected none at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk64("rd_data", rd_data, e[W-1:0]);
        chk1("rd_oob", rd_oob, e[W]);
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Reads in IDLE produce nothing
    rd_seq(0, 2);

    // Basic load of four words, read back one per cycle
    do_load(4, 0, 1'b0, 1'b0, 0);
    rd_seq(0, 4);
    chk1("load_done_one_cycle", load_done, 1'b0);

    // Out-of-range and last in-range address
    rd_seq(7, 1);
    rd_seq(3, 1);

    // Reload of 8 words with s_valid toggling; a read shares the start cycle
    do_load(8, 3, 1'b1, 1'b1, 2);
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1;
      s_data  = 64'hBAD0 + 64'(k);
      tick();
      chk1("post_load_s_ready", s_ready, 1'b0);
    end
    s_valid = 1'b0;
    rd_seq(0, 9);

    // Zero-count load
    do_load(0, 0, 1'b0, 1'b0, 0);
    tick();
    chk1("zero_load_done_clear", load_done, 1'b0);
    rd_seq(5, 1);
    rd_seq(0, 1);

    // Over-range count clamps to full depth; pattern data = address
    do_load(1100, 1, 1'b0, 1'b0, 0);
    s_valid = 1'b1;
    s_data  = 64'hFEED;
    tick();
    chk1("full_post_s_ready", s_ready, 1'b0);
    s_valid = 1'b0;
    rd_seq(0, DEPTH);

    // Reset in the middle of a 10-word load
    param_count = (AB+1)'(10);
    start = 1'b1;
    tick();
    start   = 1'b0;
    m_serve = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = beat_val(2, i);
      tick();
    end
    rst_n   = 1'b0;
    rd_req  = 1'b1;
    rd_addr = '0;
    tick();
    check_reset_outputs("midload_reset");
    rst_n    = 1'b1;
    s_valid  = 1'b0;
    m_loaded = 0;
    tick();
    chk1("idle_after_reset_rd_valid", rd_valid, 1'b0);
    chk1("idle_after_reset_s_ready",  s_ready,  1'b0);
    rd_req = 1'b0;

    // Normal load after the interrupted one
    do_load(2, 2, 1'b0, 1'b0, 0);
    rd_seq(0, 3);

    s_valid = 1'b0;
    repeat (2) tick();
    chk64("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
